// File: rtl/queue_ctrl_pkg.sv
// Shared types and helpers for the shared-queue controller.
//   qc_state_t : controller mode (normal run / flush drain)
//   cnt_w()    : occupancy counter width for a given queue depth (0..depth inclusive)
package queue_ctrl_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } qc_state_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/queue_share_ctrl_arb.sv
// Round-robin arbiter with an internal priority pointer.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset (pointer -> 0)
//   i_req        : request vector
//   i_en         : grants allowed this cycle
//   o_gnt        : one-hot grant (or zero), combinational
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_gnt
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_nxt;
  logic             w_found;

  // Scan k = 0..NUM_REQ-1 positions after the pointer; the inner loop maps the
  // circular position to a constant bit index so no variable bit-select is needed.
  always_comb begin
    o_gnt     = '0;
    w_ptr_nxt = r_ptr;
    w_found   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (i_en && !w_found && i_req[j] && (j == ((int'(r_ptr) + k) % NUM_REQ))) begin
          o_gnt[j]  = 1'b1;
          w_found   = 1'b1;
          w_ptr_nxt = PTR_W'((j + 1) % NUM_REQ);
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (|o_gnt) begin
      r_ptr <= w_ptr_nxt;
    end
  end

endmodule

// File: rtl/queue_share_ctrl.sv
// Controller sharing one queue (registered data_out, no full flag) between
// NUM_REQ producers and one consumer.
// Ports:
//   i_clk, i_rst        : clock, synchronous active-high reset (also resets the queue)
//   i_push_req/_data    : producer requests and packed data ([i*DATA_W +: DATA_W])
//   o_push_gnt          : one-hot grant, combinational
//   i_pop_req           : consumer request, one entry per cycle while high
//   o_pop_valid/_data   : dequeued entry, valid one cycle after o_q_dequeue
//   i_flush             : pulse, discard all queued entries
//   o_drain_done        : pulse when the flush has emptied the queue
//   o_count, o_full     : occupancy 0..DEPTH and count==DEPTH
//   o_err               : sticky, queue empty flag disagrees with occupancy
//   o_q_* / i_q_*       : queue-side handshake
module queue_share_ctrl
  import queue_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 2,
  parameter int DEPTH   = 256
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_REQ-1:0]        i_push_req,
  input  logic [NUM_REQ*DATA_W-1:0] i_push_data,
  output logic [NUM_REQ-1:0]        o_push_gnt,
  input  logic                      i_pop_req,
  output logic                      o_pop_valid,
  output logic [DATA_W-1:0]         o_pop_data,
  input  logic                      i_flush,
  output logic                      o_drain_done,
  output logic [$clog2(DEPTH):0]    o_count,
  output logic                      o_full,
  output logic                      o_err,
  output logic                      o_q_enqueue,
  output logic [DATA_W-1:0]         o_q_data_in,
  output logic                      o_q_dequeue,
  input  logic [DATA_W-1:0]         i_q_data_out,
  input  logic                      i_q_empty
);

  localparam int CNT_W = cnt_w(DEPTH);

  qc_state_t        r_state;
  logic [CNT_W-1:0] r_count;
  logic             r_vld_p1;
  logic             r_err;

  logic              w_run;
  logic              w_cnt_zero;
  logic              w_full;
  logic              w_arb_en;
  logic [NUM_REQ-1:0] w_gnt;
  logic [DATA_W-1:0] w_data_in;

  assign w_run      = (r_state == ST_RUN);
  assign w_cnt_zero = (r_count == '0);
  assign w_full     = (r_count == CNT_W'(DEPTH));
  // No grant at full even when a dequeue is in the same cycle.
  assign w_arb_en   = !i_rst && w_run && !w_full;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_req (i_push_req),
    .i_en  (w_arb_en),
    .o_gnt (w_gnt)
  );

  always_comb begin
    w_data_in = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_data_in = i_push_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign o_push_gnt   = w_gnt;
  assign o_q_enqueue  = |w_gnt;
  assign o_q_data_in  = w_data_in;
  // DRAIN ignores the consumer and empties the queue one entry per cycle.
  assign o_q_dequeue  = !i_rst && !w_cnt_zero && (w_run ? i_pop_req : 1'b1);
  assign o_drain_done = !i_rst && (r_state == ST_DRAIN) && w_cnt_zero;

  // ---- stage p0 -> p1: queue data_out is registered, so valid lags dequeue by one cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_RUN;
      r_count  <= '0;
      r_vld_p1 <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      unique case (r_state)
        ST_RUN:   if (i_flush)    r_state <= ST_DRAIN;
        ST_DRAIN: if (w_cnt_zero) r_state <= ST_RUN;
        default:                  r_state <= ST_RUN;
      endcase
      unique case ({o_q_enqueue, o_q_dequeue})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      // Drained entries are discarded; only RUN-cycle dequeues produce a valid.
      r_vld_p1 <= w_run && o_q_dequeue;
      r_err    <= r_err | (i_q_empty != w_cnt_zero);
    end
  end

  assign o_pop_valid = r_vld_p1;
  assign o_pop_data  = i_q_data_out;
  assign o_count     = r_count;
  assign o_full      = w_full;
  assign o_err       = r_err;

endmodule

// File: tb/tb_queue_share_ctrl.sv
module tb_queue_share_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] push_req = '0;
  logic [7:0] push_data = '0;
  logic       pop_req = 1'b0;
  logic       flush = 1'b0;
  logic [3:0] push_gnt;
  logic       pop_valid;
  logic [1:0] pop_data;
  logic       drain_done;
  logic [8:0] count;
  logic       full;
  logic       err;
  logic       q_enqueue;
  logic [1:0] q_data_in;
  logic       q_dequeue;
  logic [1:0] q_data_out;
  logic       q_empty;

  always #5 clk = ~clk;

  queue_share_ctrl #(.NUM_REQ(4), .DATA_W(2), .DEPTH(256)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_push_req   (push_req),
    .i_push_data  (push_data),
    .o_push_gnt   (push_gnt),
    .i_pop_req    (pop_req),
    .o_pop_valid  (pop_valid),
    .o_pop_data   (pop_data),
    .i_flush      (flush),
    .o_drain_done (drain_done),
    .o_count      (count),
    .o_full       (full),
    .o_err        (err),
    .o_q_enqueue  (q_enqueue),
    .o_q_data_in  (q_data_in),
    .o_q_dequeue  (q_dequeue),
    .i_q_data_out (q_data_out),
    .i_q_empty    (q_empty)
  );

  // Stand-in for the shared queue: 256 x 2-bit circular buffer, registered data_out.
  logic [1:0] qmem [256];
  logic [7:0] qwp, qrp;
  int         qn;
  assign q_empty = (qn == 0);
  always @(posedge clk) begin
    if (rst) begin
      qwp <= '0;
      qrp <= '0;
      qn  <= 0;
    end else begin
      if (q_enqueue) begin
        qmem[qwp] <= q_data_in;
        qwp <= qwp + 8'd1;
      end
      if (q_dequeue) begin
        q_data_out <= qmem[qrp];
        qrp <= qrp + 8'd1;
      end
      qn <= qn + (q_enqueue ? 1 : 0) - (q_dequeue ? 1 : 0);
    end
  end

  // Reference model: ordered list of queued values, occupancy is its length.
  logic [1:0] m_fifo [$];
  int         m_cnt = 0;
  int         m_ptr = 0;
  bit         m_drain = 1'b0;
  bit         m_vld = 1'b0;
  logic [1:0] m_vd = '0;
  bit         m_known = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void exp_comb(output logic [3:0] g, output int w, output bit deq, output bit done);
    g = '0; w = -1; deq = 1'b0; done = 1'b0;
    if (rst) return;
    if (!m_drain && m_cnt != 256) begin
      for (int k = 0; k < 4; k++) begin
        int i;
        i = (m_ptr + k) % 4;
        if (w < 0 && push_req[i]) begin
          w = i;
          g[i] = 1'b1;
        end
      end
    end
    deq  = (m_cnt != 0) && (m_drain || pop_req);
    done = m_drain && (m_cnt == 0);
  endfunction

  task automatic model_check();
    logic [3:0] g; int w; bit deq, done;
    if (!m_known) return;
    exp_comb(g, w, deq, done);
    chk("gnt", 32'(push_gnt), 32'(g));
    chk("q_enqueue", 32'(q_enqueue), 32'(|g));
    chk("q_data_in", 32'(q_data_in), (w >= 0) ? 32'(push_data[w*2 +: 2]) : 32'd0);
    chk("q_dequeue", 32'(q_dequeue), 32'(deq));
    chk("drain_done", 32'(drain_done), 32'(done));
    chk("count", 32'(count), 32'(m_cnt));
    chk("full", 32'(full), 32'(m_cnt == 256));
    chk("pop_valid", 32'(pop_valid), 32'(m_vld));
    if (m_vld) chk("pop_data", 32'(pop_data), 32'(m_vd));
    chk("err", 32'(err), 32'd0);
  endtask

  task automatic model_update();
    logic [3:0] g; int w; bit deq, done;
    exp_comb(g, w, deq, done);
    if (rst) begin
      m_fifo.delete();
      m_cnt = 0; m_ptr = 0; m_drain = 1'b0; m_vld = 1'b0; m_known = 1'b1;
    end else if (m_known) begin
      m_vld = 1'b0;
      if (deq) begin
        m_vd  = m_fifo.pop_front();
        m_vld = !m_drain;
      end
      if (w >= 0) begin
        m_fifo.push_back(push_data[w*2 +: 2]);
        m_ptr = (w + 1) % 4;
      end
      m_cnt = m_fifo.size();
      if (!m_drain && flush) m_drain = 1'b1;
      else if (done) m_drain = 1'b0;
    end
  endtask

  task automatic apply(input logic r, input logic [3:0] rq, input logic [7:0] d, input logic p, input logic f);
    @(negedge clk);
    rst = r; push_req = rq; push_data = d; pop_req = p; flush = f;
    #1;
    model_check();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
  endtask

  task automatic cyc(input logic r, input logic [3:0] rq, input logic [7:0] d, input logic p, input logic f);
    apply(r, rq, d, p, f);
    tick();
  endtask

  typedef struct {
    logic [3:0] req;
    logic       pop;
    logic [3:0] e_gnt;
    logic       e_deq;
    logic       e_vld;
    logic [1:0] e_pd;
    int         e_cnt;
  } vec_t;

  vec_t tv [10];

  initial begin
    bit seen;
    tv[0] = '{4'hf, 1'b0, 4'h1, 1'b0, 1'b0, 2'd0, 0};
    tv[1] = '{4'hf, 1'b0, 4'h2, 1'b0, 1'b0, 2'd0, 1};
    tv[2] = '{4'hf, 1'b0, 4'h4, 1'b0, 1'b0, 2'd0, 2};
    tv[3] = '{4'hf, 1'b0, 4'h8, 1'b0, 1'b0, 2'd0, 3};
    tv[4] = '{4'h0, 1'b1, 4'h0, 1'b1, 1'b0, 2'd0, 4};
    tv[5] = '{4'h0, 1'b1, 4'h0, 1'b1, 1'b1, 2'd0, 3};
    tv[6] = '{4'h0, 1'b1, 4'h0, 1'b1, 1'b1, 2'd1, 2};
    tv[7] = '{4'h0, 1'b1, 4'h0, 1'b1, 1'b1, 2'd2, 1};
    tv[8] = '{4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 2'd3, 0};
    tv[9] = '{4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 0};

    cyc(1'b1, 4'h0, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 4'h0, 8'h00, 1'b0, 1'b0);

    // Four producers with data 0..3, then four pops.
    for (int i = 0; i < 10; i++) begin
      apply(1'b0, tv[i].req, 8'he4, tv[i].pop, 1'b0);
      chk("t_gnt", 32'(push_gnt), 32'(tv[i].e_gnt));
      chk("t_deq", 32'(q_dequeue), 32'(tv[i].e_deq));
      chk("t_vld", 32'(pop_valid), 32'(tv[i].e_vld));
      if (tv[i].e_vld) chk("t_pop_data", 32'(pop_data), 32'(tv[i].e_pd));
      chk("t_count", 32'(count), 32'(tv[i].e_cnt));
      tick();
    end

    // Fill to capacity from producer 0 only.
    for (int i = 0; i < 256; i++) cyc(1'b0, 4'h1, 8'($urandom), 1'b0, 1'b0);
    apply(1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
    chk("full_flag", 32'(full), 32'd1);
    chk("full_count", 32'(count), 32'd256);
    tick();
    apply(1'b0, 4'h1, 8'h03, 1'b1, 1'b0);
    chk("full_no_gnt", 32'(push_gnt), 32'd0);
    chk("full_deq", 32'(q_dequeue), 32'd1);
    tick();
    apply(1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
    chk("full_after_pop", 32'(count), 32'd255);
    tick();

    // Flush the 255 remaining entries, producers and consumer active.
    cyc(1'b0, 4'h0, 8'h00, 1'b0, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      apply(1'b0, 4'hf, 8'($urandom), 1'b1, 1'b0);
      chk("drain_no_gnt", 32'(push_gnt), 32'd0);
      seen = drain_done;
      tick();
    end
    chk("drain_big_done", 32'(seen), 32'd1);

    // pop at empty, then flush at empty.
    apply(1'b0, 4'h0, 8'h00, 1'b1, 1'b0);
    chk("empty_no_deq", 32'(q_dequeue), 32'd0);
    tick();
    apply(1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
    chk("empty_no_vld", 32'(pop_valid), 32'd0);
    tick();
    cyc(1'b0, 4'h0, 8'h00, 1'b0, 1'b1);
    apply(1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
    chk("flush0_done", 32'(drain_done), 32'd1);
    tick();
    apply(1'b0, 4'h2, 8'h00, 1'b0, 1'b0);
    chk("flush0_run_gnt", 32'(push_gnt), 32'h2);
    tick();

    // Simultaneous push and pop at count 5.
    for (int i = 0; i < 4; i++) cyc(1'b0, 4'h1, 8'($urandom), 1'b0, 1'b0);
    apply(1'b0, 4'h1, 8'h02, 1'b1, 1'b0);
    chk("both_enq", 32'(q_enqueue), 32'd1);
    chk("both_deq", 32'(q_dequeue), 32'd1);
    chk("both_cnt_before", 32'(count), 32'd5);
    tick();
    apply(1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
    chk("both_cnt_after", 32'(count), 32'd5);
    tick();

    // Flush at count 10: ten drained dequeues, no valid, then drain_done.
    for (int i = 0; i < 5; i++) cyc(1'b0, 4'h4, 8'($urandom), 1'b0, 1'b0);
    cyc(1'b0, 4'h0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      apply(1'b0, 4'hf, 8'($urandom), 1'b1, 1'b0);
      chk("d10_deq", 32'(q_dequeue), 32'd1);
      chk("d10_gnt", 32'(push_gnt), 32'd0);
      chk("d10_vld", 32'(pop_valid), 32'd0);
      chk("d10_done", 32'(drain_done), 32'd0);
      tick();
    end
    apply(1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
    chk("d10_done_end", 32'(drain_done), 32'd1);
    chk("d10_cnt_end", 32'(count), 32'd0);
    tick();
    apply(1'b0, 4'h8, 8'hc0, 1'b0, 1'b0);
    chk("d10_run_enq", 32'(q_enqueue), 32'd1);
    tick();

    // Reset during DRAIN.
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'h3, 8'($urandom), 1'b0, 1'b0);
    cyc(1'b0, 4'h0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
    apply(1'b1, 4'h0, 8'h00, 1'b0, 1'b0);
    chk("rst_no_deq", 32'(q_dequeue), 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
      chk("rstd_count", 32'(count), 32'd0);
      chk("rstd_no_done", 32'(drain_done), 32'd0);
      tick();
    end
    apply(1'b0, 4'h1, 8'h01, 1'b0, 1'b0);
    chk("rstd_run_gnt", 32'(push_gnt), 32'h1);
    tick();

    // Reset held two cycles in the middle of traffic.
    for (int i = 0; i < 40; i++)
      cyc(1'b0, 4'($urandom), 8'($urandom), 1'($urandom), 1'b0);
    cyc(1'b1, 4'hf, 8'($urandom), 1'b1, 1'b0);
    cyc(1'b1, 4'hf, 8'($urandom), 1'b1, 1'b0);
    apply(1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_vld", 32'(pop_valid), 32'd0);
    chk("rst_gnt", 32'(push_gnt), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    tick();

    // Random traffic: heavy fill first, then mixed with flushes and resets.
    for (int i = 0; i < 700; i++)
      cyc(1'b0, 4'($urandom), 8'($urandom), ($urandom_range(0, 7) == 0), 1'b0);
    for (int i = 0; i < 1500; i++)
      cyc(($urandom_range(0, 299) == 0), 4'($urandom), 8'($urandom),
          1'($urandom), ($urandom_range(0, 63) == 0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
